// File: rtl/uart_tx_buffer.sv
// Core-to-host UART TX: byte FIFO feeding an 8N1 serializer (8E1 when UART_TX_PARITY_EN is defined).
// Latency: a write into an empty idle buffer drives the start bit one edge after acceptance.
// Backpressure: full is exported for the core's stall logic; a write while full is dropped and sets sticky overflow.
module uart_tx_buffer #(
    parameter int CLK_PER_BIT    = 868,
    parameter int FIFO_DEPTH_LOG = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        UART_write_enable,
    input  logic [31:0] data,
    output logic        full,
    output logic        busy,
    output logic        overflow,
    output logic        txd
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG;
    localparam int CW    = FIFO_DEPTH_LOG + 1;
    localparam int BW    = $clog2(CLK_PER_BIT);

    localparam logic [CW-1:0]             CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]             CNT_FULL  = CW'(DEPTH);
    localparam logic [FIFO_DEPTH_LOG-1:0] PTR_ONE   = FIFO_DEPTH_LOG'(1);
    localparam logic [BW-1:0]             BAUD_LOAD = BW'(CLK_PER_BIT - 1);
    localparam logic [BW-1:0]             BAUD_ONE  = BW'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [7:0]                mem [DEPTH];
    logic [FIFO_DEPTH_LOG-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]             count;
    logic                      empty, push, pop, load;

    logic [7:0]    shift_q, shift_nxt;
    logic [2:0]    bit_idx, bit_nxt;
    logic [BW-1:0] baud_cnt, baud_nxt;
    logic          txd_nxt, baud_zero;
    logic          par_q, par_nxt;

    logic unused_data_hi;
    assign unused_data_hi = ^data[31:8];

    assign empty     = (count == '0);
    assign full      = (count == CNT_FULL);
    assign busy      = !empty || (state != IDLE);
    assign push      = UART_write_enable && !full;
    assign baud_zero = (baud_cnt == '0);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data[7:0];
    end

    // full is sampled before the edge, so a pop in the same cycle never frees room for the push
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)      count <= count + CNT_ONE;
            else if (pop && !push) count <= count - CNT_ONE;
            if (UART_write_enable && full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (!empty) state_nxt = START;
            START: if (baud_zero) state_nxt = DATA;
            DATA: begin
                if (baud_zero && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (baud_zero) state_nxt = STOP;
`endif
            STOP:  if (baud_zero) state_nxt = empty ? IDLE : START;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load      = 1'b0;
        txd_nxt   = txd;
        shift_nxt = shift_q;
        bit_nxt   = bit_idx;
        par_nxt   = par_q;
        if (state_nxt == IDLE)             baud_nxt = '0;
        else if (state == IDLE || baud_zero) baud_nxt = BAUD_LOAD;
        else                               baud_nxt = baud_cnt - BAUD_ONE;

        case (state)
            IDLE: begin
                txd_nxt = 1'b1;
                if (!empty) load = 1'b1;
            end
            START: begin
                if (baud_zero) begin
                    txd_nxt = shift_q[0];
                    bit_nxt = 3'd0;
                end
            end
            DATA: begin
                if (baud_zero) begin
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        txd_nxt = par_q;
`else
                        txd_nxt = 1'b1;
`endif
                    end else begin
                        shift_nxt = {1'b0, shift_q[7:1]};
                        txd_nxt   = shift_q[1];
                        bit_nxt   = bit_idx + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (baud_zero) txd_nxt = 1'b1;
`endif
            STOP: begin
                if (baud_zero) begin
                    txd_nxt = 1'b1;
                    if (!empty) load = 1'b1;
                end
            end
            default: txd_nxt = 1'b1;
        endcase

        // A pop starts the next frame's start bit with no idle gap
        if (load) begin
            shift_nxt = mem[rd_ptr];
            par_nxt   = ^mem[rd_ptr];
            txd_nxt   = 1'b0;
            bit_nxt   = 3'd0;
        end
    end

    assign pop = load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            txd      <= 1'b1;
            shift_q  <= '0;
            bit_idx  <= '0;
            baud_cnt <= '0;
            par_q    <= 1'b0;
        end else begin
            txd      <= txd_nxt;
            shift_q  <= shift_nxt;
            bit_idx  <= bit_nxt;
            baud_cnt <= baud_nxt;
            par_q    <= par_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer: a line monitor decodes frames and checks them against a queue of expected bytes.
module tb_uart_tx_buffer;

    localparam int CPB = 4;
    localparam int LOG = 2;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FL = FB * CPB;

    logic        clk;
    logic        reset;
    logic        we;
    logic [31:0] data;
    logic        full, busy, overflow, txd;

    int total;
    int bad;
    int frames_rx;
    logic [7:0] exp_q[$];

    uart_tx_buffer #(.CLK_PER_BIT(CPB), .FIFO_DEPTH_LOG(LOG)) dut (
        .clk(clk),
        .reset(reset),
        .UART_write_enable(we),
        .data(data),
        .full(full),
        .busy(busy),
        .overflow(overflow),
        .txd(txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_byte(input logic [31:0] d);
        we   = 1'b1;
        data = d;
        exp_q.push_back(d[7:0]);
        @(negedge clk);
        we   = 1'b0;
    endtask

    task automatic wait_idle(input int max, output int n);
        n = 0;
        while (busy !== 1'b0 && n < max) begin
            @(negedge clk);
            n++;
        end
        check("idle_bound", 32'(n < max), 32'd1);
    endtask

    // Line monitor: every slot must be constant for CPB samples; byte compared at the last stop sample
    logic       m_act;
    int         m_pos;
    logic       m_glitch;
    logic [7:0] m_byte;
    logic       m_par;
    always @(negedge clk) begin : monitor
        int slot;
        int sub;
        logic [7:0] e;
        if (reset === 1'b1) begin
            m_act = 1'b0;
        end else if (!m_act) begin
            if (txd === 1'b0) begin
                m_act = 1'b1; m_pos = 1; m_glitch = 1'b0; m_byte = '0; m_par = 1'b0;
            end
        end else begin
            slot = m_pos / CPB;
            sub  = m_pos % CPB;
            if (slot == 0) begin
                if (txd !== 1'b0) m_glitch = 1'b1;
            end else if (slot <= 8) begin
                if (sub == 0) m_byte[slot-1] = txd;
                else if (txd !== m_byte[slot-1]) m_glitch = 1'b1;
            end else if (FB == 11 && slot == 9) begin
                if (sub == 0) m_par = txd;
                else if (txd !== m_par) m_glitch = 1'b1;
            end else if (txd !== 1'b1) begin
                m_glitch = 1'b1;
            end
            if (m_pos == FL - 1) begin
                m_act = 1'b0;
                frames_rx++;
                check("frame_shape", 32'(m_glitch), 32'd0);
                check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("frame_byte", 32'(m_byte), 32'(e));
`ifdef UART_TX_PARITY_EN
                    check("frame_parity", 32'(m_par), 32'(^e));
`endif
                end
            end else begin
                m_pos++;
            end
        end
    end

    initial begin
        int n;
        int lows;
        total = 0; bad = 0; frames_rx = 0;
        m_act = 1'b0; m_pos = 0; m_glitch = 1'b0; m_byte = '0; m_par = 1'b0;
        reset = 1'b1; we = 1'b0; data = '0;
        step(3);
        check("rst_txd", txd, 1);
        check("rst_full", full, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        reset = 1'b0;
        step(2);

        // single byte A5: start low N+1..N+4, bits 1,0,..., busy drops at N+FL+1
        write_byte(32'h0000_00A5);
        check("no_bypass_txd", txd, 1);
        check("busy_after_push", busy, 1);
        step(1);
        check("a5_start", txd, 0);
        step(4);
        check("a5_bit0", txd, 1);
        step(4);
        check("a5_bit1", txd, 0);
        step(FL - 9);
        check("a5_stop", txd, 1);
        check("a5_busy_stop", busy, 1);
        step(1);
        check("a5_busy_done", busy, 0);
        check("a5_frames", frames_rx, 1);

        // upper data bits ignored
        write_byte(32'hDEAD_BE41);
        wait_idle(2 * FL, n);
        check("b41_len", n, FL + 1);
        check("b41_frames", frames_rx, 2);
        check("b41_queue", exp_q.size(), 0);

        // back-to-back frames with no idle gap
        we = 1'b1; data = 32'h55; exp_q.push_back(8'h55);
        @(negedge clk);
        data = 32'h0F; exp_q.push_back(8'h0F);
        @(negedge clk);
        we = 1'b0;
        check("b2b_start1", txd, 0);
        step(FL - 1);
        check("b2b_stop1", txd, 1);
        step(1);
        check("b2b_no_gap", txd, 0);
        step(FL - 1);
        check("b2b_busy_end", busy, 1);
        step(1);
        check("b2b_busy_done", busy, 0);
        check("b2b_frames", frames_rx, 4);

        // six writes into a depth-4 FIFO: first popped immediately, sixth dropped
        for (int i = 0; i < 6; i++) begin
            we   = 1'b1;
            data = 32'(32'h10 + i);
            if (i < 5) exp_q.push_back(8'(8'h10 + i));
            @(negedge clk);
            check("fill_full", full, 32'(i >= 4));
            check("fill_overflow", overflow, 32'(i == 5));
        end
        we = 1'b0;
        wait_idle(6 * FL, n);
        check("fill_frames", frames_rx, 9);
        check("fill_queue", exp_q.size(), 0);
        check("overflow_sticky", overflow, 1);
        check("fill_full_drained", full, 0);

        // reset during data bit 3 aborts the frame at once
        write_byte(32'hC3);
        step(18);
        check("c3_bit3", txd, 0);
        check("c3_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("arst_txd", txd, 1);
        check("arst_busy", busy, 0);
        check("arst_full", full, 0);
        check("arst_overflow", overflow, 0);
        exp_q.delete();
        step(2);
        reset = 1'b0;
        lows = 0;
        for (int i = 0; i < 3 * FL; i++) begin
            step(1);
            if (txd !== 1'b1) lows++;
        end
        check("arst_no_residual", lows, 0);
        check("arst_frames", frames_rx, 9);

        // 07 and 03: parity 1 and 0 when the parity bit is built
        we = 1'b1; data = 32'h07; exp_q.push_back(8'h07);
        @(negedge clk);
        data = 32'h03; exp_q.push_back(8'h03);
        @(negedge clk);
        we = 1'b0;
        wait_idle(4 * FL, n);
        check("pair_len", n, 2 * FL);
        check("pair_frames", frames_rx, 11);
        check("pair_queue", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffer.md
Name: uart_tx_buffer

Overview:
- Core-to-host UART output path. Accepts the write-back stage's UART_write_enable/data strobe and queues the low byte in a small FIFO.
- Serializes queued bytes onto txd as 8N1 frames, LSB first.
- Exports full so the core's hazard logic can stall UART-write instructions, and busy for drain checks.
- Sits between the CPU core top and the board TX pin.

Parameters:
- CLK_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); legal range >= 2.
- FIFO_DEPTH_LOG, 4, log2 of FIFO entries (default 16 bytes).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- UART_write_enable  input  1  one-cycle write strobe from the write-back stage.
- data  input  32  write-back data; only data[7:0] is transmitted.
- full  output  1  FIFO holds 2^FIFO_DEPTH_LOG entries.
- busy  output  1  high when FIFO is non-empty or the FSM is not IDLE.
- overflow  output  1  sticky; set by a write attempted while full.
- txd  output  1  serial line, idles high.

Behaviour:
- Reset values: txd=1, full=0, busy=0, overflow=0, FIFO empty, FSM=IDLE, bit counter=0, baud counter=0. Reset asserted mid-frame aborts the frame immediately: txd=1 and the FIFO is flushed.
- Push: at an edge where UART_write_enable=1 and full=0, data[7:0] is written at the write pointer and count increments.
- Push while full: the byte is dropped, FIFO is unchanged, and overflow is set to 1. overflow stays at 1 until reset.
- full and empty are decoded from a registered count of width FIFO_DEPTH_LOG+1. Pointers wrap modulo depth.
- Push and pop in the same edge: count is unchanged. A push at full is rejected even if a pop occurs on the same edge; full is evaluated before that edge.
- No bypass: a byte pushed into an empty FIFO is popped no earlier than the next edge.
- FSM states: IDLE, START, DATA, STOP. txd is driven from a register.
  - IDLE: txd=1. At an edge with the FIFO non-empty, pop the head into the shift register, set txd=0, load the baud counter, and go to START.
  - START: hold for CLK_PER_BIT cycles, then txd=shift[0] and go to DATA with bit index 0.
  - DATA: each bit is held for CLK_PER_BIT cycles. After each bit, shift right and increment the index. After bit 7, txd=1 and go to STOP.
  - STOP: hold txd=1 for CLK_PER_BIT cycles. Then, if the FIFO is non-empty, pop, set txd=0 and go to START (back-to-back frames with no idle gap); otherwise go to IDLE.
- Latency: a write accepted at edge N into an empty, idle buffer drives txd low at edge N+1. The frame lasts exactly 10*CLK_PER_BIT cycles.
- Baud counter: counts CLK_PER_BIT-1 down to 0. The bit transition occurs on the edge where the counter is 0.
- busy falls to 0 on the same edge the FSM enters IDLE with the FIFO empty.
- UART_write_enable is edge-agnostic: each cycle it is high counts as one push. The core must pulse it for exactly one cycle per instruction.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: frame is 8E1. A parity state, placed between DATA and STOP, drives the even-parity bit (XOR of the 8 data bits) for CLK_PER_BIT cycles. Frame length becomes 11*CLK_PER_BIT.
- Undefined: no parity state is built; frame is 8N1 at 10*CLK_PER_BIT.

Test Plan:
- Single byte (CLK_PER_BIT=4): reset, then pulse write with data=32'h0000_00A5 at edge N -> txd=0 over cycles N+1..N+4. Data bits are 1,0,1,0,0,1,0,1, each 4 cycles. txd=1 for 4 cycles, then busy=0 at N+41.
- Upper bits ignored: data=32'hDEAD_BE41 -> serialized byte is 8'h41; frame is identical to a write of 32'h41.
- Back-to-back: write 8'h55 then 8'h0F on consecutive cycles -> the second start bit begins on the edge directly after the first stop bit ends. There is no idle-high cycle between frames; total 80 cycles.
- Full/overflow (FIFO_DEPTH_LOG=2): 6 writes on consecutive cycles while the first frame starts.
  - First write is popped at the next edge, so writes 2..5 fill the FIFO; full=1 after write 5.
  - Write 6 is dropped and overflow=1.
  - Exactly 5 frames are transmitted, in order.
- Reset mid-frame: assert reset during data bit 3 -> txd=1, busy=0, full=0 and overflow=0 immediately (asynchronous). After release, no residual frame is transmitted.
- Parity (UART_TX_PARITY_EN defined): 8'h07 -> parity bit=1; 8'h03 -> parity bit=0; each frame is 44 cycles at CLK_PER_BIT=4.
